// File: rtl/m107_video_pkg.sv
// Shared constants, CPU-port FSM states and the 5-to-8 bit colour expansion
// used by the M107 video mixer.
package m107_video_pkg;

    localparam int unsigned PAL_ENTRIES = 2048;
    localparam logic [7:0]  IO_MIX_CTRL = 8'hC0;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } cpu_st_t;

    // Replicate the top bits so 5'h1F maps to 8'hFF and 5'h00 to 8'h00.
    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

endpackage

// File: rtl/m107_palette_ram.sv
// True dual-port palette RAM: port A is the read-only pixel port, port B the
// CPU read/write port. Both reads are registered; a same-address write is not forwarded.
module m107_palette_ram
    import m107_video_pkg::*;
#(
    parameter int unsigned AddrW = $clog2(PAL_ENTRIES),
    parameter int unsigned DataW = 16
) (
    input  logic             clk,
    input  logic             a_en_i,
    input  logic [AddrW-1:0] a_addr_i,
    output logic [DataW-1:0] a_rdata_o,
    input  logic             b_en_i,
    input  logic             b_we_i,
    input  logic [AddrW-1:0] b_addr_i,
    input  logic [DataW-1:0] b_wdata_i,
    output logic [DataW-1:0] b_rdata_o
);

    localparam int unsigned Entries = 1 << AddrW;

    logic [DataW-1:0] mem [Entries];
    logic [DataW-1:0] a_rdata_q;
    logic [DataW-1:0] b_rdata_q;

    always_ff @(posedge clk) begin
        if (a_en_i) begin
            a_rdata_q <= mem[a_addr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (b_en_i) begin
            if (b_we_i) begin
                mem[b_addr_i] <= b_wdata_i;
            end
            b_rdata_q <= mem[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/m107_video_mixer.sv
// Final pixel stage: tile/sprite priority merge, palette lookup and RGB888 output,
// plus the CPU palette window and MIX_CTRL (I/O 0xC0, data taken from cpu_din_i[1:0]).
module m107_video_mixer
    import m107_video_pkg::*;
#(
    parameter int unsigned PAL_AW   = 11,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce_pix_i,
    input  logic              pal_cs_i,
    input  logic              pal_rd_i,
    input  logic              pal_wr_i,
    input  logic [PAL_AW-1:0] pal_addr_i,
    input  logic [15:0]       cpu_din_i,
    output logic [15:0]       cpu_dout_o,
    output logic              busy_o,
    input  logic              io_wr_i,
    input  logic [7:0]        io_addr_i,
    input  logic [PAL_AW-1:0] tile_color_i,
    input  logic              tile_prio_i,
    input  logic [PAL_AW-1:0] spr_color_i,
    input  logic              spr_prio_i,
    input  logic              hblank_i,
    input  logic              vblank_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              color_blank_i,
    output logic              hblank_o,
    output logic              vblank_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [7:0]        red_o,
    output logic [7:0]        green_o,
    output logic [7:0]        blue_o
);

    logic [1:0]        mix_ctrl_q;
    logic [PAL_AW-1:0] pal_idx_d, pal_idx_q;
    logic [23:0]       rgb_d, rgb_q;
    logic [3:0]        strb_q [PIPE_LAT];
    logic              blank_q [PIPE_LAT-1];
    logic [15:0]       pix_rdata;
    logic              unused_pix_msb;

    cpu_st_t           cpu_st_d, cpu_st_q;
    logic              req, req_q, start;
    logic              op_wr_q;
    logic [PAL_AW-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [15:0]       dout_q;
    logic [15:0]       cpu_rdata;
    logic              ram_b_en;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mix_ctrl_q <= '0;
        end else if (io_wr_i && io_addr_i == IO_MIX_CTRL) begin
            mix_ctrl_q <= cpu_din_i[1:0];
        end
    end

    // Stage 1: priority merge.
    always_comb begin
        logic spr_op;
        spr_op    = (|spr_color_i[3:0]) & ~mix_ctrl_q[0];
        pal_idx_d = tile_color_i;
        if (spr_op && (!tile_prio_i || spr_prio_i || tile_color_i[3:0] == 4'h0)) begin
            pal_idx_d = spr_color_i;
        end
    end

    // Stage 3: colour expansion; blank travels one stage short so it meets its pixel here.
    assign unused_pix_msb = pix_rdata[15];

    always_comb begin
        rgb_d = '0;
        if (!(blank_q[PIPE_LAT-2] || mix_ctrl_q[1])) begin
            rgb_d = {expand5(pix_rdata[4:0]), expand5(pix_rdata[9:5]),
                     expand5(pix_rdata[14:10])};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                strb_q[i] <= '0;
            end
            for (int i = 0; i < PIPE_LAT - 1; i++) begin
                blank_q[i] <= 1'b0;
            end
            pal_idx_q <= '0;
            rgb_q     <= '0;
        end else if (ce_pix_i) begin
            strb_q[0]  <= {hblank_i, vblank_i, hsync_i, vsync_i};
            blank_q[0] <= color_blank_i;
            for (int i = 1; i < PIPE_LAT; i++) begin
                strb_q[i] <= strb_q[i-1];
            end
            for (int i = 1; i < PIPE_LAT - 1; i++) begin
                blank_q[i] <= blank_q[i-1];
            end
            pal_idx_q <= pal_idx_d;
            rgb_q     <= rgb_d;
        end
    end

    assign {hblank_o, vblank_o, hsync_o, vsync_o} = strb_q[PIPE_LAT-1];
    assign {blue_o, green_o, red_o} = {rgb_q[7:0], rgb_q[15:8], rgb_q[23:16]};

    // CPU port: edge-triggered on the request so a held strobe runs one access only.
    assign req   = pal_cs_i & (pal_rd_i | pal_wr_i);
    assign start = req & ~req_q & (cpu_st_q == StIdle);

    always_comb begin
        cpu_st_d = cpu_st_q;
        unique case (cpu_st_q)
            StIdle:   if (start) cpu_st_d = StAccess;
            StAccess: cpu_st_d = StDone;
            StDone:   cpu_st_d = StIdle;
            default:  cpu_st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cpu_st_q <= StIdle;
            req_q    <= req;  // a strobe held through reset must drop before it counts
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dout_q   <= '0;
        end else begin
            cpu_st_q <= cpu_st_d;
            req_q    <= req;
            if (start) begin
                op_wr_q <= pal_wr_i;
                addr_q  <= pal_addr_i;
                wdata_q <= cpu_din_i;
            end
            if (cpu_st_q == StDone && !op_wr_q) begin
                dout_q <= cpu_rdata;
            end
        end
    end

    // Gate with reset so an access cut short by reset never writes.
    assign ram_b_en   = (cpu_st_q == StAccess) & reset_n;
    assign busy_o     = (cpu_st_q != StIdle);
    assign cpu_dout_o = dout_q;

    m107_palette_ram #(
        .AddrW(PAL_AW),
        .DataW(16)
    ) u_pal_ram (
        .clk      (clk),
        .a_en_i   (ce_pix_i),
        .a_addr_i (pal_idx_q),
        .a_rdata_o(pix_rdata),
        .b_en_i   (ram_b_en),
        .b_we_i   (op_wr_q),
        .b_addr_i (addr_q),
        .b_wdata_i(wdata_q),
        .b_rdata_o(cpu_rdata)
    );

endmodule

// File: tb/tb_m107_video_mixer.sv
// Scoreboard bench for m107_video_mixer: each pixel tick pushes its expected
// palette index/strobes; the entry is popped and compared when it reaches the output.
module tb_m107_video_mixer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_pix = 1'b0;
    logic        pal_cs = 1'b0, pal_rd = 1'b0, pal_wr = 1'b0;
    logic [10:0] pal_addr = '0;
    logic [15:0] cpu_din = '0;
    logic [15:0] cpu_dout;
    logic        busy;
    logic        io_wr = 1'b0;
    logic [7:0]  io_addr = '0;
    logic [10:0] tile_color = '0, spr_color = '0;
    logic        tile_prio = 1'b0, spr_prio = 1'b0;
    logic        hblank_in = 1'b0, vblank_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic        color_blank_in = 1'b0;
    logic        hblank, vblank, hsync, vsync;
    logic [7:0]  red, green, blue;

    always #5 clk = ~clk;

    m107_video_mixer #(
        .PAL_AW  (11),
        .PIPE_LAT(3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ce_pix_i     (ce_pix),
        .pal_cs_i     (pal_cs),
        .pal_rd_i     (pal_rd),
        .pal_wr_i     (pal_wr),
        .pal_addr_i   (pal_addr),
        .cpu_din_i    (cpu_din),
        .cpu_dout_o   (cpu_dout),
        .busy_o       (busy),
        .io_wr_i      (io_wr),
        .io_addr_i    (io_addr),
        .tile_color_i (tile_color),
        .tile_prio_i  (tile_prio),
        .spr_color_i  (spr_color),
        .spr_prio_i   (spr_prio),
        .hblank_i     (hblank_in),
        .vblank_i     (vblank_in),
        .hsync_i      (hsync_in),
        .vsync_i      (vsync_in),
        .color_blank_i(color_blank_in),
        .hblank_o     (hblank),
        .vblank_o     (vblank),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .red_o        (red),
        .green_o      (green),
        .blue_o       (blue)
    );

    typedef struct {
        logic [10:0] idx;
        logic        blank;
        logic [3:0]  strb;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] pal_m [int];
    logic [1:0]  ctrl_m = '0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [27:0] last_out = '0;
    logic [10:0] idx_set [10] = '{11'h000, 11'h011, 11'h222, 11'h045, 11'h123,
                                  11'h310, 11'h7F1, 11'h2A0, 11'h5A3, 11'h10C};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ex5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    function automatic logic [10:0] mix_m(input logic [10:0] t, input logic tp,
                                          input logic [10:0] s, input logic sp);
        if (s[3:0] != 4'h0 && !ctrl_m[0] && (!tp || sp || t[3:0] == 4'h0)) return s;
        return t;
    endfunction

    function automatic logic [23:0] rgb_m(input exp_t e);
        logic [15:0] p;
        if (e.blank || ctrl_m[1]) return 24'h0;
        p = pal_m[e.idx];
        return {ex5(p[4:0]), ex5(p[9:5]), ex5(p[14:10])};
    endfunction

    function automatic logic [27:0] outs();
        return {red, green, blue, hblank, vblank, hsync, vsync};
    endfunction

    task automatic pix_tick(input logic [10:0] t, input logic tp, input logic [10:0] s,
                            input logic sp, input logic blank, input logic [3:0] strb);
        exp_t e;
        tile_color = t; tile_prio = tp; spr_color = s; spr_prio = sp;
        color_blank_in = blank;
        {hblank_in, vblank_in, hsync_in, vsync_in} = strb;
        e.idx = mix_m(t, tp, s, sp);
        e.blank = blank;
        e.strb = strb;
        sb_q.push_back(e);
        ce_pix = 1'b1;
        @(posedge clk); #1;
        ce_pix = 1'b0;
        if (sb_q.size() >= 3) begin
            e = sb_q.pop_front();
            check_eq($sformatf("pix idx%0h rgb", e.idx), {8'h0, red, green, blue},
                     {8'h0, rgb_m(e)});
            check_eq("pix strobes", {28'h0, hblank, vblank, hsync, vsync}, {28'h0, e.strb});
            last_out = outs();
        end
    endtask

    // Clocks with ce_pix low; inputs wiggle but outputs must hold.
    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            tile_color = idx_set[$urandom_range(9)];
            color_blank_in = 1'($urandom);
            hsync_in = 1'($urandom);
            @(posedge clk); #1;
            check_eq("stall frozen", {4'h0, outs()}, {4'h0, last_out});
        end
    endtask

    task automatic io_write(input logic [7:0] a, input logic [15:0] d);
        io_wr = 1'b1; io_addr = a; cpu_din = d;
        @(posedge clk); #1;
        io_wr = 1'b0;
        if (a == 8'hC0) ctrl_m = d[1:0];
    endtask

    task automatic cpu_access(input logic wr, input logic [10:0] a, input logic [15:0] d,
                              input int hold, output int busy_cnt, output logic [15:0] dout);
        pal_cs = 1'b1; pal_wr = wr; pal_rd = ~wr; pal_addr = a; cpu_din = d;
        busy_cnt = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
        end
        pal_cs = 1'b0; pal_wr = 1'b0; pal_rd = 1'b0;
        @(posedge clk); #1;
        if (busy) busy_cnt++;
        dout = cpu_dout;
        if (wr) pal_m[a] = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bc;
        int          cnt;
        logic [15:0] d;
        logic [15:0] val;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset rgb/strobes", {4'h0, outs()}, 32'h0);
        check_eq("reset busy", {31'h0, busy}, 32'h0);
        check_eq("reset cpu_dout", {16'h0, cpu_dout}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        foreach (idx_set[i]) begin
            val = 16'($urandom);
            if (idx_set[i] == 11'h045) val = 16'h001F;
            if (idx_set[i] == 11'h123) val = 16'h7FFF;
            cpu_access(1'b1, idx_set[i], val, 4, bc, d);
            check_eq("write busy clks", bc, 2);
        end
        cpu_access(1'b0, 11'h123, 16'h0, 4, bc, d);
        check_eq("read busy clks", bc, 2);
        check_eq("read 0x123", {16'h0, d}, 32'h7FFF);
        cpu_access(1'b1, 11'h011, 16'h0C63, 4, bc, d);
        check_eq("write keeps cpu_dout", {16'h0, d}, 32'h7FFF);
        cpu_access(1'b1, 11'h222, 16'h5A5A, 10, bc, d);
        check_eq("held strobe one access", bc, 2);
        cpu_access(1'b0, 11'h222, 16'h0, 4, bc, d);
        check_eq("read 0x222", {16'h0, d}, 32'h5A5A);

        // Directed pixels.
        pix_tick(11'h045, 1'b0, 11'h000, 1'b0, 1'b0, 4'b0000);
        pix_tick(11'h011, 1'b1, 11'h222, 1'b0, 1'b0, 4'b0000);
        pix_tick(11'h011, 1'b1, 11'h222, 1'b1, 1'b0, 4'b0000);
        check_eq("tile 045 red", {24'h0, red}, 32'hFF);
        check_eq("tile 045 green/blue", {16'h0, green, blue}, 32'h0);
        pix_tick(11'h123, 1'b0, 11'h310, 1'b1, 1'b1, 4'b0010);
        pix_tick(11'h123, 1'b0, 11'h310, 1'b1, 1'b0, 4'b0010);
        pix_tick(11'h2A0, 1'b1, 11'h5A3, 1'b0, 1'b0, 4'b1000);
        io_write(8'hC0, 16'h0001);
        pix_tick(11'h011, 1'b1, 11'h222, 1'b1, 1'b0, 4'b0100);
        pix_tick(11'h000, 1'b0, 11'h7F1, 1'b0, 1'b0, 4'b0001);
        stall(20);
        pix_tick(11'h045, 1'b0, 11'h10C, 1'b0, 1'b0, 4'b0000);
        io_write(8'hC1, 16'h0003);
        pix_tick(11'h7F1, 1'b0, 11'h222, 1'b0, 1'b0, 4'b0000);
        io_write(8'hC0, 16'h0002);
        pix_tick(11'h011, 1'b0, 11'h222, 1'b0, 1'b0, 4'b1111);
        pix_tick(11'h045, 1'b0, 11'h222, 1'b0, 1'b0, 4'b0000);
        io_write(8'hC0, 16'hFFFC);
        for (int i = 0; i < 4; i++) begin
            pix_tick(idx_set[i], 1'b0, 11'h000, 1'b0, 1'b0, 4'(i));
        end

        // Random stream with occasional stalls.
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 25) io_write(8'hC0, 16'($urandom_range(3)));
            pix_tick(idx_set[$urandom_range(9)], 1'($urandom), idx_set[$urandom_range(9)],
                     1'($urandom), ($urandom_range(7) == 0), 4'($urandom));
            if ($urandom_range(9) == 0) stall($urandom_range(1, 5));
        end

        // Reset in the middle of a write.
        io_write(8'hC0, 16'h0002);
        pal_cs = 1'b1; pal_wr = 1'b1; pal_addr = 11'h045; cpu_din = 16'h1234;
        @(posedge clk); #1;
        check_eq("busy before reset", {31'h0, busy}, 32'h1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_eq("busy after reset", {31'h0, busy}, 32'h0);
        check_eq("outputs after reset", {4'h0, outs()}, 32'h0);
        reset_n = 1'b1;
        ctrl_m = '0;
        sb_q.delete();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy) cnt++;
        end
        check_eq("held strobe after reset", cnt, 0);
        pal_cs = 1'b0; pal_wr = 1'b0;
        @(posedge clk); #1;
        cpu_access(1'b0, 11'h045, 16'h0, 4, bc, d);
        check_eq("entry kept over reset", {16'h0, d}, 32'h001F);
        for (int i = 0; i < 10; i++) begin
            pix_tick(idx_set[$urandom_range(9)], 1'($urandom), idx_set[$urandom_range(9)],
                     1'($urandom), 1'b0, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
